// File: rtl/vid_dram_wr_arbiter.sv
// vid_dram_wr_arbiter
//   Two-channel DRAM write arbiter in the vid_clk domain. Each capture writer
//   pushes burst data words, then a burst command {len, addr}. Both are
//   buffered per channel, and whole bursts are replayed to one shared DRAM
//   write port, one channel at a time, in round-robin order.
//
//   Build option: define ARB_FIXED_PRIORITY_EN to make ch0 always win when
//   both channels are waiting (last_grant ignored). Default is round-robin.
//
//   Ports
//     vid_clk, rst            clock; synchronous active-high reset
//     sN_data_in/_we          channel N write word {strb[35:32], data[31:0]}
//     sN_ctrl_in/_we          channel N burst command {len[39:32], addr[31:0]}
//     m_data_out/_we          word to the DRAM data FIFO (registered)
//     m_ctrl_out/_we          burst command to DRAM (registered)
//     m_data_afull            DRAM data FIFO almost full: hold data pushes
//     m_ctrl_full             DRAM command FIFO full: hold command push
//     ovf[N]                  sticky: push to a full channel N FIFO was dropped
//     len_err[N]              sticky: channel N command with len=0 was dropped
//     busy                    arbiter is not idle

// Per-channel FIFO. A push while full is still accepted when the same cycle
// pops, since a slot frees up at that edge.
module vid_dram_wr_arbiter_fifo #(
  parameter int W  = 36,
  parameter int AW = 8
) (
  input  logic         vid_clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         we,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         drop
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop && !empty;
  assign push    = we && (!full || do_pop);
  assign drop    = we && full && !do_pop;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge vid_clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

module vid_dram_wr_arbiter #(
  parameter int DATA_AW = 8,
  parameter int CMD_AW  = 2
) (
  input  logic        vid_clk,
  input  logic        rst,
  input  logic [35:0] s0_data_in,
  input  logic        s0_data_we,
  input  logic [39:0] s0_ctrl_in,
  input  logic        s0_ctrl_we,
  input  logic [35:0] s1_data_in,
  input  logic        s1_data_we,
  input  logic [39:0] s1_ctrl_in,
  input  logic        s1_ctrl_we,
  output logic [35:0] m_data_out,
  output logic        m_data_we,
  output logic [39:0] m_ctrl_out,
  output logic        m_ctrl_we,
  input  logic        m_data_afull,
  input  logic        m_ctrl_full,
  output logic [1:0]  ovf,
  output logic [1:0]  len_err,
  output logic        busy
);
  localparam int NCH = 2;

  typedef enum logic [1:0] {IDLE, LOAD, DATA, CTRL} state_t;
  typedef struct packed {
    logic [7:0]  len;
    logic [31:0] addr;
  } cmd_t;

  state_t state, state_nx;

  logic [NCH-1:0][35:0] s_data, d_head;
  logic [NCH-1:0][39:0] s_ctrl, c_head;
  logic [NCH-1:0]       s_data_we, s_ctrl_we;
  logic [NCH-1:0]       d_empty, c_empty, d_pop, c_pop, d_drop, c_drop;

  logic       gnt, last_grant, pick;
  cmd_t       cmd_reg;
  logic [8:0] rem;

  assign s_data    = {s1_data_in, s0_data_in};
  assign s_data_we = {s1_data_we, s0_data_we};
  assign s_ctrl    = {s1_ctrl_in, s0_ctrl_in};
  assign s_ctrl_we = {s1_ctrl_we, s0_ctrl_we};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    vid_dram_wr_arbiter_fifo #(.W(36), .AW(DATA_AW)) u_data (
      .vid_clk(vid_clk), .rst(rst), .wr_data(s_data[ch]), .we(s_data_we[ch]),
      .pop(d_pop[ch]), .rd_data(d_head[ch]), .empty(d_empty[ch]), .drop(d_drop[ch]));
    vid_dram_wr_arbiter_fifo #(.W(40), .AW(CMD_AW)) u_cmd (
      .vid_clk(vid_clk), .rst(rst), .wr_data(s_ctrl[ch]), .we(s_ctrl_we[ch]),
      .pop(c_pop[ch]), .rd_data(c_head[ch]), .empty(c_empty[ch]), .drop(c_drop[ch]));
  end

  always_ff @(posedge vid_clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    pick     = 1'b0;
    c_pop    = '0;
    d_pop    = '0;
    case (state)
      IDLE: begin
        if (!c_empty[0] && !c_empty[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
          pick = 1'b0;
`else
          pick = ~last_grant;
`endif
        end else begin
          pick = c_empty[0];
        end
        if (c_empty != 2'b11) begin
          c_pop[pick] = 1'b1;
          state_nx    = LOAD;
        end
      end
      LOAD: state_nx = (cmd_reg.len == 8'd0) ? IDLE : DATA;
      DATA: begin
        // A late writer (empty FIFO) just stalls here; no timeout.
        if (!m_data_afull && !d_empty[gnt]) begin
          d_pop[gnt] = 1'b1;
          if (rem == 9'd1) state_nx = CTRL;
        end
      end
      CTRL: if (!m_ctrl_full) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;  // ch0 wins the first tie
      cmd_reg    <= '0;
      rem        <= '0;
      m_data_out <= '0;
      m_data_we  <= 1'b0;
      m_ctrl_out <= '0;
      m_ctrl_we  <= 1'b0;
      ovf        <= '0;
      len_err    <= '0;
      busy       <= 1'b0;
    end else begin
      m_data_we <= 1'b0;
      m_ctrl_we <= 1'b0;
      busy      <= (state_nx != IDLE);
      ovf       <= ovf | d_drop | c_drop;
      case (state)
        IDLE: if (state_nx == LOAD) begin
          gnt        <= pick;
          last_grant <= pick;
          cmd_reg    <= c_head[pick];
        end
        LOAD: begin
          if (cmd_reg.len == 8'd0) len_err[gnt] <= 1'b1;
          else                     rem <= {1'b0, cmd_reg.len};
        end
        DATA: if (d_pop[gnt]) begin
          m_data_we  <= 1'b1;
          m_data_out <= d_head[gnt];
          rem        <= rem - 9'd1;
        end
        CTRL: if (!m_ctrl_full) begin
          m_ctrl_we  <= 1'b1;
          m_ctrl_out <= cmd_reg;
        end
        default: ;
      endcase
    end
  end
endmodule
